// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle MIPS control unit (Moore FSM)
//
// Purpose: sequences the datapath of a multi-cycle MIPS core through
// fetch/decode/execute/memory/writeback for R, LW, SW, BEQ, ADDI and J.
// Unsupported opcodes park the FSM in ERR with a sticky illegal flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   opcode     instruction[31:26] from the instruction register
//   mem_ready  memory done this cycle (read data valid / write accepted)
//   zero       ALU zero flag, qualifies the branch PC write
//   mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource,
//   ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite
//              datapath controls, decoded from the current state
//   illegal    sticky unsupported-opcode flag
//   state_dbg  current state code
module mips_mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_ERR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;

  // Next-state decode. Anything not explicitly handled, including the
  // unused codes 12-14, falls into ERR.
  always_comb begin
    w_next = S_ERR;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_ERR;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_ERR;
      end
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_ERR;
    endcase
  end

  // State register and sticky illegal flag. The flag is set on the edge
  // that enters ERR so it is already high during the first ERR cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ERR) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Output decode. Controls are a function of the state only, except the
  // FETCH IR/PC load (qualified by mem_ready) and the branch PC load
  // (qualified by zero), which must act in the same cycle.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSource = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        PCWrite  = zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      default: begin
      end
    endcase
    // Reset must suppress every side effect immediately, even mid-wait,
    // so no partial memory or register write can slip through.
    if (rst) begin
      mem_req  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign illegal   = r_illegal;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - self-checking bench for mips_mc_control
module tb_mips_mc_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = OP_R;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegDst, MemtoReg, RegWrite, illegal;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .illegal(illegal), .state_dbg(state_dbg)
  );

  wire [16:0] w_got = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource,
                       ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal};

  // Expected controls for a state code, straight from the per-state rules.
  function automatic logic [16:0] exp_out(int st, logic rdy, logic z, logic r);
    logic mreq, iord, mrd, mwr, irw, pcw, asa, rdst, m2r, rw, ill;
    logic [1:0] pcs, asb, aop;
    mreq = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; pcw = 0; asa = 0;
    rdst = 0; m2r = 0; rw = 0; ill = 0; pcs = 0; asb = 0; aop = 0;
    case (st)
      0:  begin mreq = 1; mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mreq = 1; mrd = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mreq = 1; mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      15: ill = 1;
      default: ;
    endcase
    if (r) begin
      mreq = 0; mrd = 0; mwr = 0; irw = 0; pcw = 0; rw = 0;
    end
    return {mreq, iord, mrd, mwr, irw, pcw, pcs, asa, asb, aop, rdst, m2r, rw, ill};
  endfunction

  // One clock cycle: drive at the falling edge, compare 1ns later.
  task automatic cyc(input string name, input logic r, input logic [5:0] op,
                     input logic rdy, input logic z, input int exp_st);
    logic [16:0] e;
    @(negedge clk);
    rst = r; opcode = op; mem_ready = rdy; zero = z;
    #1;
    e = exp_out(exp_st, rdy, z, r);
    checks++;
    if (state_dbg !== exp_st[3:0]) begin
      errors++;
      $display("FAIL %s state: got=%0d expected=%0d (t=%0t)", name, state_dbg, exp_st, $time);
    end
    checks++;
    if (w_got !== e) begin
      errors++;
      $display("FAIL %s controls: got=%b expected=%b (state %0d, t=%0t)", name, w_got, e, exp_st, $time);
    end
  endtask

  typedef struct {
    logic       r;
    logic [5:0] op;
    logic       rdy;
    logic       z;
    int         st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic z, input int st);
    vec_t v;
    v.r = r; v.op = op; v.rdy = rdy; v.z = z; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    int ph[$];
    int idx;
    logic [5:0] op;
    logic rdy, z, r;

    // Table: reset state, R, FETCH waits + J, BEQ taken/not taken, ADDI, SW,
    // then reset held in FETCH with mem_ready high.
    add(0, OP_R, 1, 0, 0);  add(0, OP_R, 1, 0, 1);  add(0, OP_R, 1, 0, 6);
    add(0, OP_R, 1, 0, 7);
    add(0, OP_J, 0, 0, 0);  add(0, OP_J, 0, 0, 0);  add(0, OP_J, 0, 0, 0);
    add(0, OP_J, 1, 0, 0);  add(0, OP_J, 1, 0, 1);  add(0, OP_J, 1, 0, 11);
    add(0, OP_BEQ, 1, 1, 0); add(0, OP_BEQ, 1, 1, 1); add(0, OP_BEQ, 1, 1, 8);
    add(0, OP_BEQ, 1, 0, 0); add(0, OP_BEQ, 1, 0, 1); add(0, OP_BEQ, 1, 0, 8);
    add(0, OP_ADDI, 1, 0, 0); add(0, OP_ADDI, 1, 0, 1); add(0, OP_ADDI, 1, 0, 9);
    add(0, OP_ADDI, 1, 0, 10);
    add(0, OP_SW, 1, 0, 0); add(0, OP_SW, 1, 0, 1); add(0, OP_SW, 1, 0, 2);
    add(0, OP_SW, 1, 0, 5);
    add(1, OP_R, 1, 0, 0);  add(0, OP_R, 0, 0, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc("vec", vecs[i].r, vecs[i].op, vecs[i].rdy, vecs[i].z, vecs[i].st);
    end

    // LW with two wait cycles in MEMRD.
    cyc("lw", 0, OP_LW, 1, 0, 0);
    cyc("lw", 0, OP_LW, 0, 0, 1);
    cyc("lw", 0, OP_LW, 0, 0, 2);
    cyc("lw", 0, OP_LW, 0, 0, 3);
    cyc("lw", 0, OP_LW, 0, 0, 3);
    cyc("lw", 0, OP_LW, 1, 0, 3);
    cyc("lw", 0, OP_LW, 1, 0, 4);
    cyc("lw", 0, OP_LW, 0, 0, 0);

    // Illegal opcode: ERR holds regardless of inputs until reset.
    cyc("ill", 0, OP_BAD, 1, 0, 0);
    cyc("ill", 0, OP_BAD, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc("ill_hold", 0, OP_BAD, 1'($urandom), 1'($urandom), 15);
    end
    cyc("ill_rst", 1, OP_BAD, 1, 0, 15);
    cyc("ill_after", 0, OP_R, 0, 0, 0);

    // SW with reset landing in a MEMWR wait cycle.
    cyc("sw_rst", 0, OP_SW, 1, 0, 0);
    cyc("sw_rst", 0, OP_SW, 0, 0, 1);
    cyc("sw_rst", 0, OP_SW, 0, 0, 2);
    cyc("sw_rst", 0, OP_SW, 0, 0, 5);
    cyc("sw_rst", 1, OP_SW, 0, 0, 5);
    cyc("sw_after", 0, OP_SW, 0, 0, 0);

    // Random legal instruction stream. The model is the per-opcode list of
    // states; memory states (FETCH/MEMRD/MEMWR) linger while mem_ready is
    // low, and a reset abandons the instruction and restarts at FETCH.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: begin op = OP_R;    ph = '{0, 1, 6, 7};    end
        1: begin op = OP_LW;   ph = '{0, 1, 2, 3, 4}; end
        2: begin op = OP_SW;   ph = '{0, 1, 2, 5};    end
        3: begin op = OP_BEQ;  ph = '{0, 1, 8};       end
        4: begin op = OP_ADDI; ph = '{0, 1, 9, 10};   end
        default: begin op = OP_J; ph = '{0, 1, 11}; end
      endcase
      idx = 0;
      while (idx < ph.size()) begin
        rdy = ($urandom_range(0, 3) != 0);
        z   = 1'($urandom);
        r   = ($urandom_range(0, 59) == 0);
        cyc("rand", r, op, rdy, z, ph[idx]);
        if (r) break;
        if ((ph[idx] == 0 || ph[idx] == 3 || ph[idx] == 5) && !rdy) idx = idx;
        else idx++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
